// File: rtl/stdout_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with status register and transmit buffer.
// Define STDOUT_UART_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module stdout_uart_tx #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rstb,
    input  logic        i_clk_en,
    input  logic [23:0] i_addr,
    input  logic        i_wr,
    input  logic [31:0] i_din,
    output logic [31:0] o_dout,
    output logic        o_txd,
    output logic        o_busy
);

    localparam logic [23:0] TX_ADDR   = 24'hFFFFFE;
    localparam logic [23:0] STAT_ADDR = 24'hFFFFFD;
    localparam int unsigned BAUD_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, next_state;
    logic [BAUD_W-1:0] baud, next_baud;
    logic [2:0]        bit_idx, next_bit_idx;
    logic [7:0]        shreg, next_shreg;
    logic              next_txd;
    logic              ovf;
    logic              pop;
    logic              empty;
    logic              full;
    logic [7:0]        head;
    logic              wr_tx;
    logic              push_ok;
    logic              baud_end;
    logic              busy;
    logic              unused;

    assign wr_tx   = i_clk_en && i_wr && (i_addr == TX_ADDR);
    // A full buffer still accepts a byte when the transmitter drains one on the same edge.
    assign push_ok = wr_tx && (!full || pop);

`ifdef STDOUT_UART_FIFO_EN
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    assign head   = mem[rd_ptr];
    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign unused = ^i_din[31:8];

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_din[7:0];
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_clk_en) begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
`else
    logic [7:0] hold;
    logic       valid;

    assign head   = hold;
    assign empty  = !valid;
    assign full   = valid;
    assign unused = ^{i_din[31:8], 7'(FIFO_DEPTH)};

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            hold  <= '0;
            valid <= 1'b0;
        end else if (i_clk_en) begin
            if (push_ok) begin
                hold  <= i_din[7:0];
                valid <= 1'b1;
            end else if (pop) begin
                valid <= 1'b0;
            end
        end
    end
`endif

    // Sticky overflow: set on a dropped push, cleared by writing bit 2 of the status word.
    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            ovf <= 1'b0;
        end else if (i_clk_en) begin
            if (wr_tx && full && !pop) begin
                ovf <= 1'b1;
            end else if (i_wr && (i_addr == STAT_ADDR) && i_din[2]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            o_txd   <= 1'b1;
        end else if (i_clk_en) begin
            state   <= next_state;
            baud    <= next_baud;
            bit_idx <= next_bit_idx;
            shreg   <= next_shreg;
            o_txd   <= next_txd;
        end
    end

    assign baud_end = (baud == BAUD_W'(CLK_DIV - 1));

    always_comb begin
        next_state   = state;
        next_baud    = baud;
        next_bit_idx = bit_idx;
        next_shreg   = shreg;
        next_txd     = o_txd;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_shreg = head;
                    next_baud  = '0;
                    next_txd   = 1'b0;
                    next_state = START;
                end
            end
            START: begin
                if (baud_end) begin
                    next_baud    = '0;
                    next_bit_idx = '0;
                    next_txd     = shreg[0];
                    next_state   = DATA;
                end else begin
                    next_baud = baud + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    next_baud = '0;
                    if (bit_idx == 3'd7) begin
                        next_txd   = 1'b1;
                        next_state = STOP;
                    end else begin
                        next_bit_idx = bit_idx + 3'd1;
                        next_shreg   = {1'b0, shreg[7:1]};
                        next_txd     = shreg[1];
                    end
                end else begin
                    next_baud = baud + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    next_baud = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        next_shreg = head;
                        next_txd   = 1'b0;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    next_baud = baud + BAUD_W'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Status is forced to zero while reset is held so nothing leaks from pre-reset state.
    assign busy   = i_rstb && ((state != IDLE) || !empty);
    assign o_busy = busy;
    assign o_dout = (i_rstb && (i_addr == STAT_ADDR)) ? {29'b0, ovf, full, busy} : 32'b0;

endmodule
